// File: rtl/max4_frame_reducer.sv
// Frame-wide argmax reducer fed by the max-of-4 stage: tracks the running maximum, its beat and lane.
// Optional MAXRED_OVF_EN: saturating beat counter with sticky overflow flag on out_ovf.
module max4_frame_reducer #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_max,
    input  logic [1:0]        in_lane,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_max,
    output logic [BEAT_W-1:0] out_beat,
    output logic [1:0]        out_lane,
    output logic [BEAT_W-1:0] out_last_idx
`ifdef MAXRED_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [BEAT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  max_d;
    logic [BEAT_W-1:0] beat_d;
    logic [1:0]        lane_d;
    logic [BEAT_W-1:0] cnt_d;
    logic [BEAT_W-1:0] cnt_inc;
    logic              ovf_q, ovf_d;
    logic              ready_d, valid_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Next beat index: saturates when overflow tracking is built in, wraps otherwise
    always_comb begin
`ifdef MAXRED_OVF_EN
        cnt_inc = (out_last_idx == CNT_MAX) ? CNT_MAX : out_last_idx + BEAT_W'(1);
`else
        cnt_inc = out_last_idx + BEAT_W'(1);
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        max_d   = out_max;
        beat_d  = out_beat;
        lane_d  = out_lane;
        cnt_d   = out_last_idx;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    max_d   = in_max;
                    lane_d  = in_lane;
                    beat_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    cnt_d = cnt_inc;
                    if (out_last_idx == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end
                    // Strict compare so ties keep the earlier beat
                    if (in_max > out_max) begin
                        max_d  = in_max;
                        lane_d = in_lane;
                        beat_d = cnt_inc;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_max      <= '0;
            out_beat     <= '0;
            out_lane     <= '0;
            out_last_idx <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready     <= ready_d;
            out_valid    <= valid_d;
            out_max      <= max_d;
            out_beat     <= beat_d;
            out_lane     <= lane_d;
            out_last_idx <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef MAXRED_OVF_EN
    assign out_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_max4_frame_reducer.sv
// Scoreboard bench for max4_frame_reducer (BEAT_W=2 so the beat-counter limit is reachable).
module tb_max4_frame_reducer;

    localparam int unsigned WIDTH  = 128;
    localparam int unsigned BEAT_W = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_max;
    logic [1:0]        in_lane;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_max;
    logic [BEAT_W-1:0] out_beat;
    logic [1:0]        out_lane;
    logic [BEAT_W-1:0] out_last_idx;
`ifdef MAXRED_OVF_EN
    logic              out_ovf;
`endif

    max4_frame_reducer #(.WIDTH(WIDTH), .BEAT_W(BEAT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_max       (in_max),
        .in_lane      (in_lane),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_max      (out_max),
        .out_beat     (out_beat),
        .out_lane     (out_lane),
        .out_last_idx (out_last_idx)
`ifdef MAXRED_OVF_EN
        ,
        .out_ovf      (out_ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0]  mx;
        logic [BEAT_W-1:0] beat;
        logic [1:0]        lane;
        logic [BEAT_W-1:0] last;
        logic              ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] mx, input logic [BEAT_W-1:0] beat,
                            input logic [1:0] lane, input logic [BEAT_W-1:0] last, input logic ovf);
        exp_t e;
        e.mx = mx; e.beat = beat; e.lane = lane; e.last = last; e.ovf = ovf;
        q.push_back(e);
    endtask

    // Monitor: every output transfer is matched against the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got out_max %0h with empty scoreboard", out_max);
            end else begin
                mon_e = q.pop_front();
                check("out_max", out_max, mon_e.mx);
                check("out_beat", WIDTH'(out_beat), WIDTH'(mon_e.beat));
                check("out_lane", WIDTH'(out_lane), WIDTH'(mon_e.lane));
                check("out_last_idx", WIDTH'(out_last_idx), WIDTH'(mon_e.last));
`ifdef MAXRED_OVF_EN
                check("out_ovf", WIDTH'(out_ovf), WIDTH'(mon_e.ovf));
`endif
            end
        end
    end

    // Called and returns at posedge+1; holds the beat until accepted
    task automatic send_beat(input logic [WIDTH-1:0] v, input logic [1:0] l, input logic last);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1; in_max = v; in_lane = l; in_last = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready %0b required 1", in_ready);
                done = 1;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [WIDTH-1:0] big;
        big = (WIDTH'(1) << 127) + WIDTH'(1);
        rst_n = 1'b0; in_valid = 1'b0; in_max = '0; in_lane = '0; in_last = 1'b0; out_ready = 1'b1;

        #12;
        check("rst_in_ready", WIDTH'(in_ready), 0);
        check("rst_out_valid", WIDTH'(out_valid), 0);
        check("rst_out_max", out_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", WIDTH'(in_ready), 1);

        // Single-beat frame and one-cycle latency
        push_exp(5, 0, 2, 0, 0);
        send_beat(5, 2, 1);
        check("latency_out_valid", WIDTH'(out_valid), 1);
        check("hold_in_ready", WIDTH'(in_ready), 0);
        @(posedge clk);
        #1;
        check("after_xfer_in_ready", WIDTH'(in_ready), 1);
        check("after_xfer_out_valid", WIDTH'(out_valid), 0);

        // Four-beat frame, maximum in beat 2
        push_exp(big, 2, 3, 3, 0);
        send_beat(10, 1, 0);
        send_beat(3, 0, 0);
        send_beat(big, 3, 0);
        send_beat(7, 2, 1);
        wait_drain();

        // Tie keeps the earlier beat
        push_exp(9, 0, 0, 2, 0);
        send_beat(9, 0, 0);
        send_beat(9, 1, 0);
        send_beat(4, 2, 1);
        wait_drain();

        // Backpressure: outputs held stable, no input accepted
        out_ready = 1'b0;
        push_exp(77, 0, 1, 0, 0);
        send_beat(77, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", WIDTH'(out_valid), 1);
            check("bp_out_max", out_max, 77);
            check("bp_in_ready", WIDTH'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", WIDTH'(out_valid), 0);
        check("release_in_ready", WIDTH'(in_ready), 1);
        check("release_pending", WIDTH'(q.size()), 0);

        // Reset mid-frame discards the partial frame
        send_beat(50, 1, 0);
        send_beat(60, 2, 0);
        send_beat(70, 3, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", WIDTH'(out_valid), 0);
        check("midrst_out_max", out_max, 0);
        check("midrst_out_beat", WIDTH'(out_beat), 0);
        check("midrst_out_lane", WIDTH'(out_lane), 0);
        check("midrst_out_last_idx", WIDTH'(out_last_idx), 0);
        check("midrst_in_ready", WIDTH'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(1, 0, 0, 0, 0);
        send_beat(1, 0, 1);
        wait_drain();

        // Six-beat frame overruns a 2-bit beat counter; maximum on beat 5
`ifdef MAXRED_OVF_EN
        push_exp(50, 3, 1, 3, 1);
`else
        push_exp(50, 1, 1, 1, 0);
`endif
        send_beat(4, 0, 0);
        send_beat(1, 1, 0);
        send_beat(2, 2, 0);
        send_beat(3, 3, 0);
        send_beat(6, 0, 0);
        send_beat(50, 1, 1);
        wait_drain();

        // Following frame starts clean (overflow flag cleared)
        push_exp(8, 1, 2, 1, 0);
        send_beat(3, 1, 0);
        send_beat(8, 2, 1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/max4_frame_reducer.md
# max4_frame_reducer

- Streaming reducer directly downstream of the combinational max-of-4 stage (`max_128b`).
- Each accepted beat carries that stage's 128-bit winning value and its 2-bit lane index; the block keeps a registered running maximum across a frame of beats.
- At frame end it presents the frame-wide maximum, the beat that produced it, and the lane within that beat.
- It converts a per-beat argmax into a per-frame argmax for the ALS benchmark datapath.

## Interface
Parameters:
- `WIDTH`, 128: data width; must match the upstream max stage.
- `BEAT_W`, 8: beat-counter width; a frame holds up to 2^BEAT_W beats.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: upstream beat valid.
- `in_ready`  out  1: block can accept a beat.
- `in_max`  in  WIDTH: beat maximum, unsigned (upstream `out0`).
- `in_lane`  in  2: lane index of the beat maximum (upstream `out1`).
- `in_last`  in  1: final beat of the frame.
- `out_valid`  out  1: frame result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_max`  out  WIDTH: frame maximum.
- `out_beat`  out  BEAT_W: beat index (0-based) of the frame maximum.
- `out_lane`  out  2: lane of the frame maximum.
- `out_last_idx`  out  BEAT_W: index of the final beat, i.e. frame length minus 1.
- `out_ovf`  out  1: frame exceeded 2^BEAT_W beats. Present only with `MAXRED_OVF_EN`.

## Operation
- **States:**
  - IDLE: no beats held; `in_ready`=1.
  - ACCUM: mid-frame; `in_ready`=1.
  - HOLD: result presented; `in_ready`=0, `out_valid`=1.
- **Transfers:** an input transfer is `in_valid & in_ready`; an output transfer is `out_valid & out_ready`.
- **IDLE + input transfer:**
  - Loads `in_max`/`in_lane` unconditionally into the running registers.
  - Sets best-beat = 0 and beat counter = 0.
  - Goes to HOLD if `in_last`, else ACCUM.
- **ACCUM + input transfer:**
  - Increments the beat counter first.
  - Replaces the running best only if `in_max` > current best (unsigned, strict), recording the new beat index and lane.
  - Ties keep the earlier beat.
  - Goes to HOLD if `in_last`.
- **HOLD:**
  - Outputs are stable while `out_valid`=1 and `out_ready`=0.
  - On output transfer, goes to IDLE.
  - Inputs are ignored (`in_ready`=0).
- **Output mapping:** `out_max`, `out_beat`, `out_lane` and `out_last_idx` are direct register outputs, valid only when `out_valid`=1.
- **Beat-counter limit:** when the counter is at 2^BEAT_W−1 and another beat is accepted, behaviour is set by the configuration macro.
- **Reset:**
  - All outputs and registers clear to 0; state goes to IDLE.
  - Reset mid-frame or in HOLD discards the partial frame or pending result; no output is produced for it.

## Timing
- A last beat accepted at edge k gives `out_valid`=1 after edge k (latency 1 cycle from the acceptance edge).
- Output transfer at edge m gives `in_ready`=1 after m. The earliest next-frame beat is accepted at edge m+1, so there is one bubble per frame.
- Minimum frame period is (beats + 1) cycles, assuming `out_ready` is held high.
- There is no combinational path from `out_ready` to `in_ready`, nor from `in_valid` to any output.
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 (IDLE) from the first cycle after release. `out_valid`, `out_max`, `out_beat`, `out_lane`, `out_last_idx` and `out_ovf` are all 0.

## Configuration
- `MAXRED_OVF_EN` defined:
  - The beat counter saturates at 2^BEAT_W−1.
  - Further beats are still compared, and a winner among them records beat index 2^BEAT_W−1.
  - A sticky overflow bit sets and is reported on `out_ovf` with the result; it clears on output transfer.
- `MAXRED_OVF_EN` undefined:
  - No `out_ovf` port and no overflow bit.
  - The beat counter and `out_last_idx` wrap modulo 2^BEAT_W.

## Test plan
- **Single-beat frame:** `in_max`=5, `in_lane`=2, `in_last`=1 → next cycle `out_valid`=1, `out_max`=5, `out_beat`=0, `out_lane`=2, `out_last_idx`=0.
- **Four-beat frame with max in beat 2:** values 10/3/2^127+1/7, lanes 1/0/3/2 → `out_max`=2^127+1, `out_beat`=2, `out_lane`=3, `out_last_idx`=3.
- **Tie:** beats 9 (lane 0), 9 (lane 1), 4 → `out_beat`=0, `out_lane`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 throughout. On release, one transfer occurs, then `in_ready`=1 the following cycle.
- **Reset mid-frame:** 3 beats of a frame accepted, `rst_n` pulsed low → all outputs 0 immediately. A new 1-beat frame with value 1 then yields `out_max`=1, `out_beat`=0.
- **Overflow with BEAT_W=2, 6-beat frame, max on beat 5:**
  - With `MAXRED_OVF_EN`: `out_ovf`=1, `out_beat`=3, `out_last_idx`=3.
  - Without the macro: `out_beat`=1, `out_last_idx`=1.
